controller_sequencer: RTL and testbench
=======================================

// Module: controller_sequencer
// PURPOSE
//   SAP-1 control unit, directly downstream of the instruction register.
//   - Consumes the 4-bit opcode (I7..I4) on I_sequencer.
//   - Runs a 6-state one-hot ring counter (T1..T6).
//   - Decodes {opcode, T-state} into the 12-bit control word CON that drives
//     the PC, MAR, RAM, IR, accumulator, ALU, B and output registers.
//   - Latches HLT.
// PARAMETERS
//   OP_LDA  4'b0000  load accumulator from memory
//   OP_ADD  4'b0001  A <= A + B(mem)
//   OP_SUB  4'b0010  A <= A - B(mem)
//   OP_OUT  4'b1110  output register <= A
//   OP_HLT  4'b1111  stop the sequencer
// PORTS
//   clk          in   1   system clock; state changes on the FALLING edge
//   clr          in   1   asynchronous, active-high reset
//   I_sequencer  in   4   opcode from instruction register (Data[7:4])
//   CON          out  12  {Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}
//   t_state      out  6   one-hot ring state, bit0=T1 .. bit5=T6
//   hlt          out  1   1 = halted; the clock module gates clk with it
// BEHAVIOUR
//   - Reset (clr=1, any time, async): t_state=6'b000001 (T1), hlt=0.
//     CON = 12'h5E3 while clr is held. An instruction in flight is abandoned.
//   - State register updates on negedge clk. CON is a pure decode of
//     {t_state, I_sequencer, hlt}. Control lines are therefore stable at every
//     posedge, where the datapath registers load.
//   - Ring: T1->T2->...->T6->T1, one state per clock.
//   - Fetch, opcode-independent:
//       T1 5E3 (Ep, nLm)
//       T2 BE3 (Cp)
//       T3 263 (nCE, nLi)
//   - Execute (T4/T5/T6):
//       LDA  1A3 / 2C3 / 3E3
//       ADD  1A3 / 2E1 / 3C7
//       SUB  1A3 / 2E1 / 3CF
//       OUT  3F2 / 3E3 / 3E3
//       HLT  3E3, see below
//       any other opcode  3E3 / 3E3 / 3E3 (NOP)
//   - I_sequencer is only meaningful in T4..T6. The IR loads at the T3 posedge.
//     The opcode is ignored in T1..T3.
//   - HLT: at the negedge ending T4 with I_sequencer==OP_HLT:
//       hlt <= 1 and t_state freezes at T4.
//     While hlt=1: CON=12'h3E3, no state change, I_sequencer ignored.
//     Only clr exits halt. hlt is a registered output.
//   - I_sequencer changing mid-execute (not expected) is decoded as-is each
//     cycle. No latching inside this block.
//   - t_state is always exactly one-hot. Any illegal value (e.g. SEU) is
//     recovered to T1 on the next negedge.
// CONFIGURATION
//   VAR_CYCLE_EN
//     undefined: fixed 6-state machine cycle for every instruction.
//     defined: variable machine cycle; the ring returns to T1 right after
//     the last active state:
//       - LDA: T5->T1
//       - OUT: T4->T1
//       - NOP/unknown opcode: T4->T1
//       - ADD/SUB: full 6 states
//       - HLT: unchanged
//     In both builds, CON values in the states that are visited are identical.
// TESTING
//   1. Assert clr mid-T5 of an ADD -> t_state=000001, hlt=0, CON=5E3
//      immediately, without waiting for a clk edge.
//   2. Opcode 0000 over 6 negedges -> CON sequence
//      5E3,BE3,263,1A3,2C3,3E3, then back to 5E3.
//   3. Opcode 0010 -> T4..T6 CON = 1A3,2E1,3CF. Opcode 0001 -> 1A3,2E1,3C7.
//   4. Opcode 1111 -> hlt rises at the negedge after T4. t_state stays 001000
//      and CON=3E3 for 20 clocks. clr then restores T1 and hlt=0.
//   5. Opcode 0101 (undefined) -> T4..T6 CON all 3E3, hlt stays 0.
//   6. VAR_CYCLE_EN defined:
//        OUT program -> T1,T2,T3,T4,T1
//        LDA -> 5 states
//        ADD -> 6 states
//      Count clocks per instruction: 4/5/6.

Source files
------------

// File: rtl/controller_sequencer.sv
// controller_sequencer -- SAP-1 control unit.
//
// Runs a 6-state one-hot ring counter (T1..T6) on the falling edge of clk.
// It decodes {T-state, opcode, hlt} into the 12-bit control word CON, so the
// control lines are settled before the datapath registers load at posedge.
// An HLT opcode seen in T4 latches hlt and freezes the ring. Only clr releases
// it.
//
// Ports
//   clk          in   1   system clock; state advances on the falling edge
//   clr          in   1   asynchronous active-high reset (T1, hlt=0)
//   I_sequencer  in   4   opcode from the instruction register (Data[7:4])
//   CON          out  12  {Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}
//   t_state      out  6   one-hot ring state, bit0=T1 .. bit5=T6
//   hlt          out  1   registered halt flag (gates clk in the clock module)
//
// Build option
//   VAR_CYCLE_EN  when defined, the ring returns to T1 right after the last
//                 active state of each instruction:
//                   LDA 5 states, ADD/SUB 6 states, OUT/NOP 4 states.
//                 Undefined: every instruction takes all 6 states.

module controller_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  I_sequencer,
  output logic [11:0] CON,
  output logic [5:0]  t_state,
  output logic        hlt
);

  typedef enum logic [3:0] {
    OP_LDA = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_OUT = 4'b1110,
    OP_HLT = 4'b1111
  } opcode_e;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  // Control words. The bit order is {Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}.
  localparam logic [11:0] CW_IDLE    = 12'h3E3;  // every active-low line deasserted
  localparam logic [11:0] CW_FETCH1  = 12'h5E3;  // Ep, nLm
  localparam logic [11:0] CW_FETCH2  = 12'hBE3;  // Cp
  localparam logic [11:0] CW_FETCH3  = 12'h263;  // nCE, nLi
  localparam logic [11:0] CW_ADDR    = 12'h1A3;  // nLm, nEi: operand address to MAR
  localparam logic [11:0] CW_LDA_T5  = 12'h2C3;  // nCE, nLa
  localparam logic [11:0] CW_MEM_B   = 12'h2E1;  // nCE, nLb
  localparam logic [11:0] CW_ADD_T6  = 12'h3C7;  // nLa, Eu
  localparam logic [11:0] CW_SUB_T6  = 12'h3CF;  // nLa, Su, Eu
  localparam logic [11:0] CW_OUT_T4  = 12'h3F2;  // Ea, nLo

  tstate_e state_q, state_d;
  logic    hlt_q, hlt_d;

  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      state_q <= T1;
      hlt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hlt_q   <= hlt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = T1;
    hlt_d   = hlt_q;

    if (hlt_q) begin
      // Hold the frozen state. A corrupted (non-one-hot) value still falls
      // back to T1.
      case (state_q)
        T1, T2, T3, T4, T5, T6: state_d = state_q;
        default:                state_d = T1;
      endcase
    end else begin
      case (state_q)
        T1: state_d = T2;
        T2: state_d = T3;
        T3: state_d = T4;
        T4: begin
          if (I_sequencer == OP_HLT) begin
            hlt_d   = 1'b1;
            state_d = T4;
          end else begin
`ifdef VAR_CYCLE_EN
            case (I_sequencer)
              OP_LDA, OP_ADD, OP_SUB: state_d = T5;
              default:                state_d = T1;
            endcase
`else
            state_d = T5;
`endif
          end
        end
        T5: begin
`ifdef VAR_CYCLE_EN
          case (I_sequencer)
            OP_ADD, OP_SUB: state_d = T6;
            default:        state_d = T1;
          endcase
`else
          state_d = T6;
`endif
        end
        T6:      state_d = T1;
        default: state_d = T1;
      endcase
    end
  end

  // Control-word decode. It is purely combinational on the registered state,
  // so clr forces the T1 word at once.
  always_comb begin
    CON = CW_IDLE;
    if (!hlt_q) begin
      case (state_q)
        T1: CON = CW_FETCH1;
        T2: CON = CW_FETCH2;
        T3: CON = CW_FETCH3;
        T4: begin
          case (I_sequencer)
            OP_LDA, OP_ADD, OP_SUB: CON = CW_ADDR;
            OP_OUT:                 CON = CW_OUT_T4;
            default:                CON = CW_IDLE;
          endcase
        end
        T5: begin
          case (I_sequencer)
            OP_LDA:         CON = CW_LDA_T5;
            OP_ADD, OP_SUB: CON = CW_MEM_B;
            default:        CON = CW_IDLE;
          endcase
        end
        T6: begin
          case (I_sequencer)
            OP_ADD:  CON = CW_ADD_T6;
            OP_SUB:  CON = CW_SUB_T6;
            default: CON = CW_IDLE;
          endcase
        end
        default: CON = CW_IDLE;
      endcase
    end
  end

  assign t_state = state_q;
  assign hlt     = hlt_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// tb_controller_sequencer -- directed bench for the SAP-1 control unit.
// The driver moves the state on each falling edge. For every clock it queues
// the {CON, t_state, hlt} expected at the following rising edge, where the
// datapath would sample them. A monitor pops the queue at each rising edge
// and compares it with the outputs.

module tb_controller_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  I_sequencer;
  logic [11:0] CON;
  logic [5:0]  t_state;
  logic        hlt;

  controller_sequencer dut (
    .clk        (clk),
    .clr        (clr),
    .I_sequencer(I_sequencer),
    .CON        (CON),
    .t_state    (t_state),
    .hlt        (hlt)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] S1 = 6'b000001;
  localparam logic [5:0] S2 = 6'b000010;
  localparam logic [5:0] S3 = 6'b000100;
  localparam logic [5:0] S4 = 6'b001000;
  localparam logic [5:0] S5 = 6'b010000;
  localparam logic [5:0] S6 = 6'b100000;

  // Opcode driven during fetch. HLT is used so that acting on the opcode too
  // early shows up.
  localparam logic [3:0] JUNK = 4'hF;

  typedef struct packed {
    logic [15:0] tag;
    logic [11:0] con;
    logic [5:0]  ts;
    logic        h;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   tag      = 0;

  task automatic expect_now(input logic [11:0] con, input logic [5:0] ts, input logic h);
    exp_t e;
    e.tag = 16'(tag);
    e.con = con;
    e.ts  = ts;
    e.h   = h;
    sb.push_back(e);
    tag++;
  endtask

  // Drive the opcode for the current state and queue the expected outputs.
  // Then advance past the next falling edge.
  task automatic step(input logic [3:0] op, input logic [11:0] con,
                      input logic [5:0] ts, input logic h);
    I_sequencer = op;
    expect_now(con, ts, h);
    @(negedge clk);
    #1;
  endtask

  // Number of execute states the ring visits for an opcode.
  function automatic int exec_len(input logic [3:0] op);
`ifdef VAR_CYCLE_EN
    case (op)
      4'b0000:          return 2;
      4'b0001, 4'b0010: return 3;
      default:          return 1;
    endcase
`else
    return 3;
`endif
  endfunction

  task automatic run_instr(input logic [3:0] op, input logic [11:0] c4,
                           input logic [11:0] c5, input logic [11:0] c6);
    int n;
    n = exec_len(op);
    step(JUNK, 12'h5E3, S1, 1'b0);
    step(JUNK, 12'hBE3, S2, 1'b0);
    step(JUNK, 12'h263, S3, 1'b0);
    step(op, c4, S4, 1'b0);
    if (n >= 2) step(op, c5, S5, 1'b0);
    if (n >= 3) step(op, c6, S6, 1'b0);
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(posedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        n_checks++;
        if ({CON, t_state, hlt} === {e.con, e.ts, e.h})
          n_pass++;
        else
          $display("FAIL step%0d: CON=%h t_state=%b hlt=%b, expected CON=%h t_state=%b hlt=%b",
                   e.tag, CON, t_state, hlt, e.con, e.ts, e.h);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion within 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    clr         = 1'b1;
    I_sequencer = JUNK;
    @(negedge clk);
    #1;
    // With clr held, the outputs show the reset state.
    step(JUNK, 12'h5E3, S1, 1'b0);
    clr = 1'b0;

    run_instr(4'b0000, 12'h1A3, 12'h2C3, 12'h3E3);  // LDA
    run_instr(4'b0001, 12'h1A3, 12'h2E1, 12'h3C7);  // ADD
    run_instr(4'b0010, 12'h1A3, 12'h2E1, 12'h3CF);  // SUB
    run_instr(4'b1110, 12'h3F2, 12'h3E3, 12'h3E3);  // OUT
    run_instr(4'b0101, 12'h3E3, 12'h3E3, 12'h3E3);  // undefined -> NOP
    run_instr(4'b1010, 12'h3E3, 12'h3E3, 12'h3E3);  // undefined -> NOP

    // clr is asserted mid-T5 of an ADD. The reset state must appear at the
    // next rising edge, before any falling edge.
    step(JUNK, 12'h5E3, S1, 1'b0);
    step(JUNK, 12'hBE3, S2, 1'b0);
    step(JUNK, 12'h263, S3, 1'b0);
    step(4'b0001, 12'h1A3, S4, 1'b0);
    I_sequencer = 4'b0001;
    #1;
    clr = 1'b1;
    expect_now(12'h5E3, S1, 1'b0);
    @(negedge clk);
    #1;
    clr = 1'b0;

    // HLT: the ring freezes at T4 and hlt rises after the T4 falling edge.
    step(JUNK, 12'h5E3, S1, 1'b0);
    step(JUNK, 12'hBE3, S2, 1'b0);
    step(JUNK, 12'h263, S3, 1'b0);
    step(4'b1111, 12'h3E3, S4, 1'b0);
    for (int i = 0; i < 20; i++)
      step(4'(i), 12'h3E3, S4, 1'b1);

    // Only clr leaves halt.
    #1;
    clr = 1'b1;
    expect_now(12'h5E3, S1, 1'b0);
    @(negedge clk);
    #1;
    clr = 1'b0;

    run_instr(4'b0000, 12'h1A3, 12'h2C3, 12'h3E3);  // LDA after halt recovery
    step(JUNK, 12'h5E3, S1, 1'b0);

    // Let the monitor drain the queue, with a bounded wait.
    for (int k = 0; k < 5 && sb.size() > 0; k++)
      @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      n_checks = n_checks + sb.size();
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
